// File: rtl/kl_slice_adder_seq.sv
// Multi-cycle KL10 word adder: drives one SLICE-bit carry-lookahead slice per
// clock, LSB group first, and hands back sum/cout/ovf behind valid/ready.

module kl_cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         pp;

  // Each carry is a flat sum of generate terms gated by the propagate chain,
  // so no carry depends on a lower carry signal.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    c  = '0;
    pp = 1'b0;
    g  = a & b;
    p  = a ^ b;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
  end

  assign s    = p ^ c[W-1:0];
  assign cout = c[W];
endmodule

module kl_slice_adder_seq #(
  parameter  int WIDTH  = 36,
  parameter  int SLICE  = 4,
  localparam int NSLICE = WIDTH / SLICE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [0:WIDTH-1]          a,
  input  logic [0:WIDTH-1]          b,
  input  logic                      cin,
  input  logic                      sub,
  input  logic                      abort,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [0:WIDTH-1]          sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy,
  output logic [$clog2(NSLICE)-1:0] slice_idx
);
  localparam int IDXW = $clog2(NSLICE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [0:WIDTH-1] a_r;
  logic [0:WIDTH-1] b_r;
  logic [0:WIDTH-1] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic [IDXW-1:0]  idx_r;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;
  logic             last_slice;

  // Bit 0 is the word MSB, so slice k sits at the high-index end for k=0.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_r == IDXW'(i)) begin
        a_sl = a_r[WIDTH-SLICE*(i+1) +: SLICE];
        b_sl = b_r[WIDTH-SLICE*(i+1) +: SLICE];
      end
    end
  end

  kl_cla_slice #(.W(SLICE)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_r),
    .s    (s_sl),
    .cout (c_sl)
  );

  assign last_slice = (idx_r == IDXW'(NSLICE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: operand, carry and result registers are all cleared on reset so
    // the outputs are defined immediately, not just once res_valid rises.
    if (!reset_n) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      idx_r   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            idx_r   <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            idx_r <= '0;
            state <= S_IDLE;
          end else begin
            for (int i = 0; i < NSLICE; i++) begin
              if (idx_r == IDXW'(i)) sum_r[WIDTH-SLICE*(i+1) +: SLICE] <= s_sl;
            end
            carry_r <= c_sl;
            if (last_slice) begin
              // Carry into bit 0 is recovered from its operand and sum bits.
              cout_r <= c_sl;
              ovf_r  <= c_sl ^ (a_r[0] ^ b_r[0] ^ s_sl[SLICE-1]);
              idx_r  <= '0;
              state  <= S_DONE;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (state == S_IDLE);
  assign busy        = (state == S_RUN);
  assign res_valid   = (state == S_DONE);
  assign sum         = sum_r;
  assign cout        = cout_r;
  assign ovf         = ovf_r;
  assign slice_idx   = idx_r;
endmodule

// File: tb/tb_kl_slice_adder_seq.sv
// Directed self-checking bench for kl_slice_adder_seq: hand-computed octal
// vectors, latency/busy counting, DONE hold, abort and async reset cases.

module tb_kl_slice_adder_seq;
  logic        clk;
  logic        reset_n;
  logic        start_valid;
  logic        start_ready;
  logic [0:35] a;
  logic [0:35] b;
  logic        cin;
  logic        sub;
  logic        abort;
  logic        res_valid;
  logic        res_ready;
  logic [0:35] sum;
  logic        cout;
  logic        ovf;
  logic        busy;
  logic [3:0]  slice_idx;

  int checks   = 0;
  int failures = 0;

  kl_slice_adder_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy),
    .slice_idx   (slice_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request from a negedge; leaves the bench at the negedge after
  // the acceptance edge with the input pins scrambled.
  task automatic accept(input string tag, input logic [0:35] ta, input logic [0:35] tb_v,
                        input logic tcin, input logic tsub);
    check({tag, ":start_ready"}, start_ready, 1);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub;
  endtask

  task automatic do_op(input string tag, input logic [0:35] ta, input logic [0:35] tb_v,
                       input logic tcin, input logic tsub,
                       input logic [0:35] es, input logic ec, input logic eo, input int hold);
    int lat;
    int busy_n;
    int k;
    accept(tag, ta, tb_v, tcin, tsub);
    lat = 0; busy_n = 0; k = 0;
    while (!res_valid && lat < 20) begin
      if (busy) begin
        busy_n++;
        check({tag, ":slice_idx"}, slice_idx, k);
        k++;
      end
      step();
      lat++;
    end
    check({tag, ":latency"}, lat, 9);
    check({tag, ":busy_cycles"}, busy_n, 9);
    check({tag, ":sum"}, sum, es);
    check({tag, ":cout"}, cout, ec);
    check({tag, ":ovf"}, ovf, eo);
    for (int i = 0; i < hold; i++) begin
      start_valid = ~start_valid;
      a = ~a; b = ~b;
      step();
      check({tag, ":hold_sum"}, sum, es);
      check({tag, ":hold_start_ready"}, start_ready, 0);
      check({tag, ":hold_res_valid"}, res_valid, 1);
      check({tag, ":hold_busy"}, busy, 0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, ":res_valid_after"}, res_valid, 0);
    check({tag, ":start_ready_after"}, start_ready, 1);
  endtask

  task automatic wait_idx(input string tag, input logic [3:0] k);
    int n;
    n = 0;
    while (slice_idx !== k && n < 20) begin
      step();
      n++;
    end
    check({tag, ":reach_idx"}, slice_idx, k);
  endtask

  task automatic abort_at(input string tag, input logic [3:0] k, input logic [0:35] es);
    logic seen;
    wait_idx(tag, k);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check({tag, ":busy"}, busy, 0);
    check({tag, ":start_ready"}, start_ready, 1);
    check({tag, ":sum_partial"}, sum, es);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | res_valid;
      step();
    end
    check({tag, ":no_res_valid"}, seen, 0);
  endtask

  initial begin
    reset_n = 1'b0; start_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; abort = 1'b0; res_ready = 1'b0;
    #12;
    check("rst:start_ready", start_ready, 1);
    check("rst:busy", busy, 0);
    check("rst:res_valid", res_valid, 0);
    check("rst:sum", sum, 0);
    check("rst:cout", cout, 0);
    check("rst:ovf", ovf, 0);
    check("rst:slice_idx", slice_idx, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("add1",   36'o000000000001, 36'o000000000001, 1'b0, 1'b0, 36'o000000000002, 1'b0, 1'b0, 0);
    do_op("ripple", 36'o777777777777, 36'o000000000000, 1'b1, 1'b0, 36'o000000000000, 1'b1, 1'b0, 0);
    do_op("sub53",  36'o000000000005, 36'o000000000003, 1'b1, 1'b1, 36'o000000000002, 1'b1, 1'b0, 0);
    do_op("sub35",  36'o000000000003, 36'o000000000005, 1'b0, 1'b1, 36'o777777777776, 1'b0, 1'b0, 0);
    do_op("ovfpos", 36'o377777777777, 36'o000000000001, 1'b0, 1'b0, 36'o400000000000, 1'b0, 1'b1, 0);
    do_op("ovfneg", 36'o400000000000, 36'o400000000000, 1'b0, 1'b0, 36'o000000000000, 1'b1, 1'b1, 0);
    do_op("hold",   36'o123456701234, 36'o654321076543, 1'b0, 1'b0, 36'o777777777777, 1'b0, 1'b0, 5);

    // Slices 0..3 overwrite the low 16 bits with zero; slice 4 is aborted.
    accept("abort4", 36'o777777777777, 36'o000000000000, 1'b1, 1'b0);
    abort_at("abort4", 4'd4, 36'hF_FFFF_0000);
    do_op("post_abort", 36'o000000000003, 36'o000000000005, 1'b0, 1'b1, 36'o777777777776, 1'b0, 1'b0, 0);

    // Abort on the final slice keeps the previous top nibble.
    accept("abort8", 36'o000000000001, 36'o000000000001, 1'b0, 1'b0);
    abort_at("abort8", 4'd8, 36'hF_0000_0002);
    do_op("post_abort8", 36'o000000000005, 36'o000000000003, 1'b0, 1'b1, 36'o000000000002, 1'b1, 1'b0, 0);

    accept("midrst", 36'o777777777777, 36'o000000000000, 1'b1, 1'b0);
    wait_idx("midrst", 4'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst:start_ready", start_ready, 1);
    check("midrst:busy", busy, 0);
    check("midrst:res_valid", res_valid, 0);
    check("midrst:sum", sum, 0);
    check("midrst:cout", cout, 0);
    check("midrst:ovf", ovf, 0);
    check("midrst:slice_idx", slice_idx, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 36'o400000000000, 36'o400000000000, 1'b0, 1'b0, 36'o000000000000, 1'b1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
